// File: rtl/seq_div_6by3.sv
// seq_div_6by3 - sequential restoring divider (6-bit dividend / 3-bit divisor).
//
// Produces one quotient bit per clock after a start pulse. The result is
// registered on the cycle done pulses and held until the next completion.
// A start seen in the completion cycle is accepted, so operations can run
// back-to-back.
//
// Parameters:
//   DW  dividend / quotient width (default 6)
//   VW  divisor / remainder width (default 3)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        request pulse, sampled on the rising edge of clk
//   dividend     numerator, sampled with start
//   divisor      denominator, sampled with start
//   busy         high while a division is in progress
//   done         one-cycle pulse when the results become valid
//   quotient     registered quotient (all ones on divide by zero)
//   remainder    registered remainder (zero on divide by zero)
//   div_by_zero  registered; set with done when the captured divisor was 0
//   check_err    (DIV_SELFCHECK_EN only) set with done when
//                quotient*divisor+remainder differs from the dividend
//
// Optional feature macro: DIV_SELFCHECK_EN
module seq_div_6by3 #(
    parameter int DW = 6,
    parameter int VW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
`ifdef DIV_SELFCHECK_EN
    output logic          check_err,
`endif
    output logic          div_by_zero
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_count;
    logic [VW:0]   r_prem;      // partial remainder
    logic [DW-1:0] r_shift;     // dividend shifting out, quotient shifting in
    logic [VW-1:0] r_divisor;
    logic          r_busy;
    logic          r_done;
    logic [DW-1:0] r_quot;
    logic [VW-1:0] r_rem;
    logic          r_dz;

    logic [VW:0]   w_shifted;
    logic [VW+1:0] w_trial;
    logic          w_qbit;
    logic [VW:0]   w_prem_next;
    logic [DW-1:0] w_shift_next;
    logic          w_last;
    logic          w_div_zero;
    logic          w_unused;

    // The partial remainder stays below the divisor, so its top bit is
    // always zero before the shift; only the lower VW bits feed the shift.
    assign w_shifted    = {r_prem[VW-1:0], r_shift[DW-1]};
    assign w_trial      = {1'b0, w_shifted} - {2'b00, r_divisor};
    assign w_qbit       = ~w_trial[VW+1];
    assign w_prem_next  = w_qbit ? w_trial[VW:0] : w_shifted;
    assign w_shift_next = {r_shift[DW-2:0], w_qbit};
    assign w_last       = (r_count == LAST_ITER);
    assign w_div_zero   = (r_divisor == '0);
    assign w_unused     = r_prem[VW];

`ifdef DIV_SELFCHECK_EN
    logic [DW-1:0]   r_dividend;
    logic            r_chk;
    logic [DW+VW:0]  w_product;
    logic [DW+VW:0]  w_recon;
    logic            w_mismatch;

    // Rebuild the dividend from the final quotient/remainder of this edge.
    assign w_product  = {{(VW+1){1'b0}}, w_shift_next} * {{(DW+1){1'b0}}, r_divisor};
    assign w_recon    = w_product + {{(DW+1){1'b0}}, w_prem_next[VW-1:0]};
    assign w_mismatch = (w_recon != {{(VW+1){1'b0}}, r_dividend});
    assign check_err  = r_chk;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_prem    <= '0;
            r_shift   <= '0;
            r_divisor <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_dz      <= 1'b0;
`ifdef DIV_SELFCHECK_EN
            r_dividend <= '0;
            r_chk      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_shift   <= dividend;
                        r_divisor <= divisor;
                        r_prem    <= '0;
                        r_count   <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
`ifdef DIV_SELFCHECK_EN
                        r_dividend <= dividend;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_prem  <= w_prem_next;
                    r_shift <= w_shift_next;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_quot  <= w_div_zero ? '1 : w_shift_next;
                        r_rem   <= w_div_zero ? '0 : w_prem_next[VW-1:0];
                        r_dz    <= w_div_zero;
`ifdef DIV_SELFCHECK_EN
                        r_chk   <= ~w_div_zero & w_mismatch;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dz;

endmodule

// File: tb/tb_seq_div_6by3.sv
module tb_seq_div_6by3;

    localparam int DW = 6;
    localparam int VW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
`ifdef DIV_SELFCHECK_EN
    logic          check_err;
`endif

    seq_div_6by3 #(.DW(DW), .VW(VW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
`ifdef DIV_SELFCHECK_EN
        .check_err   (check_err),
`endif
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned q;
        int unsigned r;
        int unsigned dz;
        int unsigned due;
        int unsigned a;
        int unsigned b;
    } exp_t;

    exp_t        sb[$];
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc   = 0;
    logic        mon_en = 1'b0;
    int unsigned last_q = 0, last_r = 0, last_dz = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain unsigned division, with the divide-by-zero rule.
    function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned due);
        exp_t e;
        e.a = a; e.b = b; e.due = due;
        if (b == 0) begin
            e.q = (1 << DW) - 1; e.r = 0; e.dz = 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 0;
        end
        return e;
    endfunction

    // Drive start in the current cycle; the sampling edge is the next one.
    task automatic issue_now(input int unsigned a, input int unsigned b);
        start    = 1'b1;
        dividend = DW'(a);
        divisor  = VW'(b);
        sb.push_back(model(a, b, cyc + 1 + DW));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input int unsigned a, input int unsigned b);
        @(negedge clk);
        issue_now(a, b);
    endtask

    task automatic wait_done();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout_pending", sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: pops the scoreboard on every done and checks hold otherwise.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && !rst) begin
                if (done) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_done: done=1 q=%0d r=%0d, expected no completion", quotient, remainder);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("quotient %0d/%0d", e.a, e.b), quotient, e.q);
                        check($sformatf("remainder %0d/%0d", e.a, e.b), remainder, e.r);
                        check($sformatf("div_by_zero %0d/%0d", e.a, e.b), div_by_zero, e.dz);
                        check($sformatf("done_cycle %0d/%0d", e.a, e.b), cyc, e.due);
`ifdef DIV_SELFCHECK_EN
                        check($sformatf("check_err %0d/%0d", e.a, e.b), check_err, 0);
`endif
                        last_q = e.q; last_r = e.r; last_dz = e.dz;
                    end
                end else begin
                    check("held_quotient", quotient, last_q);
                    check("held_remainder", remainder, last_r);
                    check("held_div_by_zero", div_by_zero, last_dz);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned bad;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, done, quotient, remainder, div_by_zero}, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // 42/5 with busy profile over the run.
        issue(42, 5);
        bad = 0;
        for (int i = 0; i < DW; i++) begin
            if (busy !== 1'b1) bad++;
            @(negedge clk);
        end
        check("busy_high_cycles_missed", bad, 0);
        check("busy_low_in_done", busy, 0);
        check("done_pulse_cycle", done, 1);
        wait_done();

        issue(63, 7); wait_done();
        issue(5, 7);  wait_done();
        issue(49, 0); wait_done();
        issue(12, 3); wait_done();

        // start during RUN must be ignored.
        issue(50, 6);
        @(negedge clk);
        start = 1'b1; dividend = 6'd7; divisor = 3'd1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_ignored_start", busy, 1);
        wait_done();

        // Back-to-back: new start accepted in the DONE cycle.
        issue(33, 5);
        repeat (DW - 1) @(negedge clk);
        @(negedge clk);
        check("in_done_cycle", done, 1);
        issue_now(20, 6);
        wait_done();

        // Reset in the middle of 60/4.
        issue(60, 4);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        last_q = 0; last_r = 0; last_dz = 0;
        #1;
        check("reset_midop_outputs", {busy, done, quotient, remainder, div_by_zero}, 0);
        @(negedge clk);
        rst = 1'b0;
        issue_now(60, 4);
        wait_done();

        // Exhaustive sweep over non-zero divisors.
        for (int unsigned a = 0; a < 64; a++)
            for (int unsigned b = 1; b < 8; b++) begin
                issue(a, b);
                wait_done();
            end

        // Random operations, random gaps, occasional ignored start in RUN,
        // occasional back-to-back issue from the DONE cycle.
        for (int i = 0; i < 150; i++) begin
            int unsigned a = $urandom_range(0, 63);
            int unsigned b = $urandom_range(0, 7);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(a, b);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, DW - 2)) @(negedge clk);
                start = 1'b1;
                dividend = 6'($urandom_range(0, 63));
                divisor  = 3'($urandom_range(0, 7));
                @(negedge clk);
                start = 1'b0;
                wait_done();
            end else if ($urandom_range(0, 1) == 0) begin
                repeat (DW) @(negedge clk);
                issue_now($urandom_range(0, 63), $urandom_range(0, 7));
                wait_done();
            end else begin
                wait_done();
            end
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
